// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the framed PISO serializer.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shift_reg_piso_core.sv
// WIDTH-bit load/shift-left register with asynchronous clear and an MSB tap.
module shift_reg_piso_core
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             msb
);

  logic [WIDTH-1:0] shift_reg;

  // Load wins over shift so a fresh word is never corrupted by a stale shift request.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= load_data;
    end else if (shift) begin
      shift_reg <= shift_reg << 1;
    end
  end

  assign msb = shift_reg[WIDTH-1];

endmodule

// File: rtl/serializer_piso_framed.sv
// Framed MSB-first serializer: valid/ready word intake, serial bit stream with strobes, optional gap.
module serializer_piso_framed
  import serializer_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             word_done
);

  localparam int BCW = cnt_width(WIDTH);
  localparam int GCW = cnt_width(GAP_CYCLES + 1);

  state_t         state, state_d;
  logic [BCW-1:0] bit_cnt, bit_cnt_d;
  logic [GCW-1:0] gap_cnt, gap_cnt_d;
  logic           serial_out_d, bit_valid_d, frame_start_d, word_done_d;
  logic           accept, core_load, core_shift, core_msb;

  shift_reg_piso_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .clear     (clear),
    .load      (core_load),
    .shift     (core_shift),
    .load_data (parallel_in << 1),
    .msb       (core_msb)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      serial_out  <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      word_done   <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      gap_cnt     <= gap_cnt_d;
      serial_out  <= serial_out_d;
      bit_valid   <= bit_valid_d;
      frame_start <= frame_start_d;
      word_done   <= word_done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latches are inferred.
  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    gap_cnt_d     = gap_cnt;
    serial_out_d  = serial_out;
    bit_valid_d   = bit_valid;
    frame_start_d = 1'b0;
    word_done_d   = 1'b0;

    if (accept) begin
      state_d       = SHIFT;
      bit_cnt_d     = BCW'(WIDTH - 1);
      serial_out_d  = parallel_in[WIDTH-1];
      bit_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      word_done_d   = (WIDTH == 1);
    end else begin
      unique case (state)
        IDLE: begin
          serial_out_d = 1'b0;
          bit_valid_d  = 1'b0;
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            serial_out_d = core_msb;
            bit_cnt_d    = bit_cnt - BCW'(1);
            word_done_d  = (bit_cnt == BCW'(1));
          end else if (GAP_CYCLES > 0) begin
            state_d      = GAP;
            gap_cnt_d    = GCW'(GAP_CYCLES - 1);
            serial_out_d = 1'b0;
            bit_valid_d  = 1'b0;
          end else begin
            state_d      = IDLE;
            serial_out_d = 1'b0;
            bit_valid_d  = 1'b0;
          end
        end
        GAP: begin
          serial_out_d = 1'b0;
          bit_valid_d  = 1'b0;
          if (gap_cnt == '0) state_d = IDLE;
          else               gap_cnt_d = gap_cnt - GCW'(1);
        end
        default: begin
          state_d      = IDLE;
          serial_out_d = 1'b0;
          bit_valid_d  = 1'b0;
        end
      endcase
    end
  end

  // Handshake and datapath control; the ready path chains back-to-back words only without a gap.
  always_comb begin
    load_ready = (state == IDLE) ||
                 (state == SHIFT && bit_cnt == '0 && GAP_CYCLES == 0);
    accept     = load_valid && load_ready;
    core_load  = accept;
    core_shift = !accept && (state == SHIFT) && (bit_cnt != '0);
  end

endmodule

// File: tb/tb_serializer_piso_framed.sv
// Bench for serializer_piso_framed: vector tables, corner sequences and a randomized model comparison.
module tb_serializer_piso_framed;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       lv0 = 1'b0, lv2 = 1'b0;
  logic [3:0] pi0 = '0, pi2 = '0;
  logic       rdy0, so0, bv0, fs0, wd0;
  logic       rdy2, so2, bv2, fs2, wd2;
  logic [3:0] sipo;

  int n_checks = 0;
  int n_fail   = 0;

  serializer_piso_framed #(.WIDTH(4), .GAP_CYCLES(0)) dut (
    .clk(clk), .clear(clear), .load_valid(lv0), .load_ready(rdy0), .parallel_in(pi0),
    .serial_out(so0), .bit_valid(bv0), .frame_start(fs0), .word_done(wd0)
  );

  serializer_piso_framed #(.WIDTH(4), .GAP_CYCLES(2)) dut_gap (
    .clk(clk), .clear(clear), .load_valid(lv2), .load_ready(rdy2), .parallel_in(pi2),
    .serial_out(so2), .bit_valid(bv2), .frame_start(fs2), .word_done(wd2)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit left-shifting SIPO fed by the no-gap serializer.
  always @(posedge clk or posedge clear) begin
    if (clear)    sipo <= '0;
    else if (bv0) sipo <= {sipo[2:0], so0};
  end

  // Observation vector: {load_ready, serial_out, bit_valid, frame_start, word_done}
  typedef struct {
    logic       lv;
    logic [3:0] pi;
    logic [4:0] exp;
  } vec_t;

  typedef struct {
    logic       bv;
    logic       out;
    logic       fs;
    logic [3:0] pend;
    int         pend_n;
    int         gap;
  } model_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] obs(input bit g);
    return g ? {rdy2, so2, bv2, fs2, wd2} : {rdy0, so0, bv0, fs0, wd0};
  endfunction

  function automatic vec_t mk(input logic lv, input logic [3:0] pi, input logic [4:0] exp);
    vec_t v;
    v.lv = lv; v.pi = pi; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input bit g, input logic lv, input logic [3:0] pi);
    if (g) begin lv2 = lv; pi2 = pi; end
    else   begin lv0 = lv; pi0 = pi; end
  endtask

  task automatic run_vec(input string name, input vec_t v, input bit g);
    drive(g, v.lv, v.pi);
    check(name, obs(g), v.exp);
    tick();
  endtask

  task automatic pulse_clear();
    #2 clear = 1'b1;
    #2 clear = 1'b0;
    tick();
  endtask

  // Reference model: a word in flight is the displayed bit plus a count of bits still owed.
  function automatic logic model_ready(input model_t m, input int gapc);
    return (!m.bv && m.gap == 0) || (m.bv && m.pend_n == 0 && gapc == 0);
  endfunction

  function automatic logic [4:0] model_obs(input model_t m, input int gapc);
    return {model_ready(m, gapc), m.out, m.bv, m.fs, m.bv && m.pend_n == 0};
  endfunction

  function automatic model_t model_step(input model_t m, input logic lv, input logic [3:0] pi,
                                        input int gapc);
    model_t n = m;
    n.fs = 1'b0;
    if (lv && model_ready(m, gapc)) begin
      n.bv = 1'b1; n.out = pi[3]; n.pend = pi << 1; n.pend_n = 3; n.fs = 1'b1; n.gap = 0;
    end else if (m.bv && m.pend_n > 0) begin
      n.out = m.pend[3]; n.pend = m.pend << 1; n.pend_n = m.pend_n - 1;
    end else if (m.bv) begin
      n.bv = 1'b0; n.out = 1'b0; n.gap = gapc;
    end else if (m.gap > 0) begin
      n.gap = m.gap - 1;
    end
    return n;
  endfunction

  vec_t   tbl_b2b[10];
  vec_t   tbl_gap[13];
  vec_t   tbl_hold[6];
  model_t m0, m2, m_rst;

  initial begin
    tbl_b2b[0] = mk(1, 4'b1010, 5'b10000);
    tbl_b2b[1] = mk(1, 4'b0110, 5'b01110);
    tbl_b2b[2] = mk(1, 4'b0110, 5'b00100);
    tbl_b2b[3] = mk(1, 4'b0110, 5'b01100);
    tbl_b2b[4] = mk(1, 4'b0110, 5'b10101);
    tbl_b2b[5] = mk(0, 4'b0000, 5'b00110);
    tbl_b2b[6] = mk(0, 4'b0000, 5'b01100);
    tbl_b2b[7] = mk(0, 4'b0000, 5'b01100);
    tbl_b2b[8] = mk(0, 4'b0000, 5'b10101);
    tbl_b2b[9] = mk(0, 4'b0000, 5'b10000);

    tbl_gap[0]  = mk(1, 4'b1100, 5'b10000);
    tbl_gap[1]  = mk(1, 4'b0011, 5'b01110);
    tbl_gap[2]  = mk(1, 4'b0011, 5'b01100);
    tbl_gap[3]  = mk(1, 4'b0011, 5'b00100);
    tbl_gap[4]  = mk(1, 4'b0011, 5'b00101);
    tbl_gap[5]  = mk(1, 4'b0011, 5'b00000);
    tbl_gap[6]  = mk(1, 4'b0011, 5'b00000);
    tbl_gap[7]  = mk(1, 4'b0011, 5'b10000);
    tbl_gap[8]  = mk(0, 4'b0000, 5'b00110);
    tbl_gap[9]  = mk(0, 4'b0000, 5'b00100);
    tbl_gap[10] = mk(0, 4'b0000, 5'b01100);
    tbl_gap[11] = mk(0, 4'b0000, 5'b01101);
    tbl_gap[12] = mk(0, 4'b0000, 5'b00000);

    tbl_hold[0] = mk(1, 4'b1111, 5'b10000);
    tbl_hold[1] = mk(1, 4'b0000, 5'b01110);
    tbl_hold[2] = mk(1, 4'b0000, 5'b01100);
    tbl_hold[3] = mk(1, 4'b0000, 5'b01100);
    tbl_hold[4] = mk(0, 4'b0000, 5'b11101);
    tbl_hold[5] = mk(0, 4'b0000, 5'b10000);

    m_rst = '{bv: 1'b0, out: 1'b0, fs: 1'b0, pend: 4'b0, pend_n: 0, gap: 0};

    // Asynchronous clear with no clock edge in between
    #2 clear = 1'b1;
    #1;
    check("reset_obs", obs(0), 5'b10000);
    check("reset_obs_gap", obs(1), 5'b10000);
    check("reset_sipo", sipo, 4'b0000);
    tick();
    #2 clear = 1'b0;
    tick();

    // Single word 1010, then confirm a downstream SIPO holds it
    drive(0, 1, 4'b1010);
    check("single_c0", obs(0), 5'b10000);
    tick();
    drive(0, 0, 4'b0000);
    check("single_c1", obs(0), 5'b01110);
    tick();
    check("single_c2", obs(0), 5'b00100);
    tick();
    check("single_c3", obs(0), 5'b01100);
    tick();
    check("single_c4", obs(0), 5'b10101);
    tick();
    check("single_sipo", sipo, 4'b1010);
    check("single_idle", obs(0), 5'b10000);

    for (int i = 0; i < 10; i++) run_vec($sformatf("b2b_c%0d", i), tbl_b2b[i], 0);
    check("b2b_sipo", sipo, 4'b0110);
    for (int i = 0; i < 13; i++) run_vec($sformatf("gap_c%0d", i), tbl_gap[i], 1);
    for (int i = 0; i < 6; i++)  run_vec($sformatf("hold_c%0d", i), tbl_hold[i], 0);

    // Clear mid-word aborts the word without a word_done pulse
    drive(0, 1, 4'b1011);
    tick();
    drive(0, 0, 4'b0000);
    check("abort_c1", obs(0), 5'b01110);
    tick();
    check("abort_c2", obs(0), 5'b00100);
    #2 clear = 1'b1;
    #1;
    check("abort_async", obs(0), 5'b10000);
    tick();
    check("abort_held1", obs(0), 5'b10000);
    tick();
    check("abort_held2", obs(0), 5'b10000);
    #2 clear = 1'b0;
    drive(0, 1, 4'b0101);
    check("abort_next_ready", obs(0), 5'b10000);
    tick();
    drive(0, 0, 4'b0000);
    check("abort_next_c1", obs(0), 5'b00110);
    tick();
    check("abort_next_c2", obs(0), 5'b01100);
    tick();
    check("abort_next_c3", obs(0), 5'b00100);
    tick();
    check("abort_next_c4", obs(0), 5'b11101);
    tick();
    check("abort_next_sipo", sipo, 4'b0101);

    // Randomized traffic on both variants against the reference model
    pulse_clear();
    m0 = m_rst;
    m2 = m_rst;
    for (int c = 0; c < 400; c++) begin
      logic       l0, l2;
      logic [3:0] p0, p2;
      l0 = ($urandom_range(0, 3) != 0);
      l2 = ($urandom_range(0, 2) == 0);
      p0 = 4'($urandom);
      p2 = 4'($urandom);
      drive(0, l0, p0);
      drive(1, l2, p2);
      check($sformatf("rand_nogap_c%0d", c), obs(0), model_obs(m0, 0));
      check($sformatf("rand_gap_c%0d", c), obs(1), model_obs(m2, 2));
      m0 = model_step(m0, l0, p0, 0);
      m2 = model_step(m2, l2, p2, 2);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
